// File: rtl/neander_pkg.sv
// rtl/neander_pkg.sv - shared types and sizes for the Neander memory/RDM block
// NEANDER_MEM_PARITY_EN widens each stored word by one even-parity bit.
package neander_pkg;

    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 8;
    localparam int MEM_DEPTH = 256;

`ifdef NEANDER_MEM_PARITY_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic even_par(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/neander_ram256x8.sv
// rtl/neander_ram256x8.sv - 256-word storage, synchronous write, asynchronous read
// NEANDER_MEM_PARITY_EN adds a stored parity bit and a read-side mismatch flag.
module neander_ram256x8
    import neander_pkg::*;
(
    input  logic              clock,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
`ifdef NEANDER_MEM_PARITY_EN
    output logic              o_par_err,
`endif
    output logic [DATA_W-1:0] o_rdata
);

    // No reset on purpose: contents survive a controller reset.
    logic [WORD_W-1:0] r_mem [MEM_DEPTH];
    logic [WORD_W-1:0] w_word_rd;

`ifdef NEANDER_MEM_PARITY_EN
    logic [WORD_W-1:0] w_word_wr;
    assign w_word_wr = {even_par(i_wdata), i_wdata};
    assign o_par_err = w_word_rd[DATA_W] != even_par(w_word_rd[DATA_W-1:0]);
`else
    logic [WORD_W-1:0] w_word_wr;
    assign w_word_wr = i_wdata;
`endif

    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_addr] <= w_word_wr;
        end
    end

    assign w_word_rd = r_mem[i_addr];
    assign o_rdata   = w_word_rd[DATA_W-1:0];

endmodule

// File: rtl/neander_mem_rdm.sv
// rtl/neander_mem_rdm.sv - Neander memory access FSM with wait states and RDM register
// NEANDER_MEM_PARITY_EN adds the perr output driven by the parity-protected storage.
module neander_mem_rdm
    import neander_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] EndMem,
    input  logic              req_rd,
    input  logic              req_wr,
    input  logic [DATA_W-1:0] dataIn,
    output logic [DATA_W-1:0] RDM,
    output logic              ready,
`ifdef NEANDER_MEM_PARITY_EN
    output logic              perr,
`endif
    output logic              busy
);

    localparam logic [2:0] CNT_LAST = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

    state_t            r_state;
    state_t            w_next;
    logic [2:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_is_wr;
    logic              w_accept;
    logic              w_we;
    logic [DATA_W-1:0] w_rdata;

    assign w_accept = (r_state == IDLE) && (req_rd || req_wr);
    // Reset wins over the DONE edge so an aborted write never lands.
    assign w_we     = (r_state == DONE) && r_is_wr && !reset;
    assign busy     = (r_state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = (WAIT_CYCLES == 0) ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (r_cnt == CNT_LAST) begin
                    w_next = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= 3'd0;
        end else if ((r_state == WAIT) && (w_next == WAIT)) begin
            r_cnt <= r_cnt + 3'd1;
        end else begin
            r_cnt <= 3'd0;
        end
    end

    // A simultaneous read/write request is treated as a write.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_addr  <= '0;
            r_data  <= '0;
            r_is_wr <= 1'b0;
        end else if (w_accept) begin
            r_addr  <= EndMem;
            r_data  <= dataIn;
            r_is_wr <= req_wr;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            RDM   <= '0;
            ready <= 1'b0;
        end else begin
            ready <= (r_state == DONE);
            if (r_state == DONE) begin
                RDM <= r_is_wr ? r_data : w_rdata;
            end
        end
    end

`ifdef NEANDER_MEM_PARITY_EN
    logic w_par_err;

    always_ff @(posedge clock) begin
        if (reset || w_accept) begin
            perr <= 1'b0;
        end else if ((r_state == DONE) && !r_is_wr) begin
            perr <= w_par_err;
        end
    end

    neander_ram256x8 u_ram (
        .clock     (clock),
        .i_we      (w_we),
        .i_addr    (r_addr),
        .i_wdata   (r_data),
        .o_par_err (w_par_err),
        .o_rdata   (w_rdata)
    );
`else
    neander_ram256x8 u_ram (
        .clock   (clock),
        .i_we    (w_we),
        .i_addr  (r_addr),
        .i_wdata (r_data),
        .o_rdata (w_rdata)
    );
`endif

endmodule

// File: tb/tb_neander_mem_rdm.sv
// tb/tb_neander_mem_rdm.sv - directed self-checking bench for neander_mem_rdm
// Define NEANDER_MEM_PARITY_EN to also exercise the parity path.
module tb_neander_mem_rdm;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] EndMem;
    logic       req_rd;
    logic       req_wr;
    logic [7:0] dataIn;

    logic [7:0] rdm1, rdm0, rdm7;
    logic       ready1, ready0, ready7;
    logic       busy1, busy0, busy7;
`ifdef NEANDER_MEM_PARITY_EN
    logic       perr1, perr0, perr7;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

`ifdef NEANDER_MEM_PARITY_EN
    neander_mem_rdm #(.WAIT_CYCLES(1)) dut (
        .clock(clock), .reset(reset), .EndMem(EndMem), .req_rd(req_rd), .req_wr(req_wr),
        .dataIn(dataIn), .RDM(rdm1), .ready(ready1), .perr(perr1), .busy(busy1));
    neander_mem_rdm #(.WAIT_CYCLES(0)) dut0 (
        .clock(clock), .reset(reset), .EndMem(EndMem), .req_rd(req_rd), .req_wr(req_wr),
        .dataIn(dataIn), .RDM(rdm0), .ready(ready0), .perr(perr0), .busy(busy0));
    neander_mem_rdm #(.WAIT_CYCLES(7)) dut7 (
        .clock(clock), .reset(reset), .EndMem(EndMem), .req_rd(req_rd), .req_wr(req_wr),
        .dataIn(dataIn), .RDM(rdm7), .ready(ready7), .perr(perr7), .busy(busy7));
`else
    neander_mem_rdm #(.WAIT_CYCLES(1)) dut (
        .clock(clock), .reset(reset), .EndMem(EndMem), .req_rd(req_rd), .req_wr(req_wr),
        .dataIn(dataIn), .RDM(rdm1), .ready(ready1), .busy(busy1));
    neander_mem_rdm #(.WAIT_CYCLES(0)) dut0 (
        .clock(clock), .reset(reset), .EndMem(EndMem), .req_rd(req_rd), .req_wr(req_wr),
        .dataIn(dataIn), .RDM(rdm0), .ready(ready0), .busy(busy0));
    neander_mem_rdm #(.WAIT_CYCLES(7)) dut7 (
        .clock(clock), .reset(reset), .EndMem(EndMem), .req_rd(req_rd), .req_wr(req_wr),
        .dataIn(dataIn), .RDM(rdm7), .ready(ready7), .busy(busy7));
`endif

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Issues one access on the W=1 instance; lat counts edges from accept to ready.
    task automatic do_access(input logic rd, input logic wr, input logic [7:0] addr,
                             input logic [7:0] data, output int lat);
        req_rd = rd;
        req_wr = wr;
        EndMem = addr;
        dataIn = data;
        tick();
        req_rd = 1'b0;
        req_wr = 1'b0;
        lat = 99;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (ready1) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, lat0, lat7, nb0, nb7, np0, np7, npulse;
        logic [7:0] cap;

        reset = 1'b0; req_rd = 1'b0; req_wr = 1'b0; EndMem = '0; dataIn = '0;
        do_reset();
        check_eq("reset_rdm", rdm1, 8'h00);
        check_eq("reset_ready", ready1, 1'b0);
        check_eq("reset_busy", busy1, 1'b0);
`ifdef NEANDER_MEM_PARITY_EN
        check_eq("reset_perr", perr1, 1'b0);
`endif

        do_access(1'b0, 1'b1, 8'h10, 8'hA5, lat);
        check_eq("wr10_lat", lat, 2);
        check_eq("wr10_rdm", rdm1, 8'hA5);
        do_access(1'b1, 1'b0, 8'h10, 8'h00, lat);
        check_eq("rd10_lat", lat, 2);
        check_eq("rd10_rdm", rdm1, 8'hA5);

        // Latency and busy span for WAIT_CYCLES = 0 and 7.
        do_reset();
        lat0 = 99; lat7 = 99; nb0 = 0; nb7 = 0; np0 = 0; np7 = 0;
        req_rd = 1'b1; EndMem = 8'h10;
        tick();
        req_rd = 1'b0;
        nb0 += busy0; nb7 += busy7;
        for (int k = 1; k <= 12; k++) begin
            tick();
            nb0 += busy0; nb7 += busy7;
            np0 += ready0; np7 += ready7;
            if (ready0 && lat0 == 99) lat0 = k;
            if (ready7 && lat7 == 99) lat7 = k;
        end
        check_eq("w0_lat", lat0, 1);
        check_eq("w7_lat", lat7, 8);
        check_eq("w0_busy", nb0, 1);
        check_eq("w7_busy", nb7, 8);
        check_eq("w0_pulses", np0, 1);
        check_eq("w7_pulses", np7, 1);

        // Simultaneous read and write: write wins.
        do_access(1'b0, 1'b1, 8'hFF, 8'h00, lat);
        do_access(1'b1, 1'b1, 8'hFF, 8'h3C, lat);
        check_eq("rdwr_lat", lat, 2);
        check_eq("rdwr_rdm", rdm1, 8'h3C);
        do_access(1'b1, 1'b0, 8'hFF, 8'h00, lat);
        check_eq("rdwr_mem", rdm1, 8'h3C);

        // Request and address change while busy are ignored.
        do_access(1'b0, 1'b1, 8'h40, 8'h5A, lat);
        do_access(1'b0, 1'b1, 8'h00, 8'hEE, lat);
        req_rd = 1'b1; EndMem = 8'h40;
        tick();
        EndMem = 8'h00;
        tick();
        req_rd = 1'b0;
        npulse = 0; cap = 8'h00;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (ready1) begin
                npulse++;
                cap = rdm1;
            end
        end
        check_eq("busy_pulses", npulse, 1);
        check_eq("busy_rdm", cap, 8'h5A);

        // Read directly after write to the same address.
        do_access(1'b0, 1'b1, 8'h50, 8'hC3, lat);
        do_access(1'b1, 1'b0, 8'h50, 8'h00, lat);
        check_eq("raw_rdm", rdm1, 8'hC3);

        // Reset during WAIT aborts a write.
        do_access(1'b0, 1'b1, 8'h20, 8'h11, lat);
        req_wr = 1'b1; EndMem = 8'h20; dataIn = 8'h77;
        tick();
        req_wr = 1'b0;
        check_eq("abort_busy_pre", busy1, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("abort_rdm", rdm1, 8'h00);
        check_eq("abort_busy", busy1, 1'b0);
        npulse = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            npulse += ready1;
        end
        check_eq("abort_ready", npulse, 0);
        do_access(1'b1, 1'b0, 8'h20, 8'h00, lat);
        check_eq("abort_mem", rdm1, 8'h11);

`ifdef NEANDER_MEM_PARITY_EN
        do_access(1'b0, 1'b1, 8'h30, 8'h81, lat);
        dut.u_ram.r_mem[8'h30][8] = ~dut.u_ram.r_mem[8'h30][8];
        do_access(1'b1, 1'b0, 8'h30, 8'h00, lat);
        check_eq("par_bad_perr", perr1, 1'b1);
        check_eq("par_bad_ready", ready1, 1'b1);
        check_eq("par_bad_rdm", rdm1, 8'h81);
        do_access(1'b1, 1'b0, 8'h10, 8'h00, lat);
        check_eq("par_clean_perr", perr1, 1'b0);
        check_eq("par_clean_rdm", rdm1, 8'hA5);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/neander_mem_rdm.md
NEANDER_MEM_RDM -- requirements
Module: neander_mem_rdm

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, meaning the wait states inserted per access (legal 0..7).
REQ-002 SHALL have port clock  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  synchronous reset, active-high.
REQ-004 SHALL have port EndMem  input  8  memory address from the PC/REM address path.
REQ-005 SHALL have port req_rd  input  1  read request, sampled only in IDLE.
REQ-006 SHALL have port req_wr  input  1  write request, sampled only in IDLE.
REQ-007 SHALL have port dataIn  input  8  write data from AC.
REQ-008 SHALL have port RDM  output  8  memory data register, read result or last write data.
REQ-009 SHALL have port ready  output  1  one-cycle pulse marking access completion.
REQ-010 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-011 SHALL hold a 256 x 8 storage array addressed by the full 8-bit EndMem, with no wrap logic needed.
REQ-012 SHALL implement FSM states IDLE, WAIT and DONE.
REQ-013 In IDLE, req_rd or req_wr high SHALL accept the request, latch EndMem and dataIn, record the operation, and move to WAIT (WAIT_CYCLES>0) or DONE (WAIT_CYCLES=0).
REQ-014 WAIT SHALL count exactly WAIT_CYCLES cycles with a 3-bit counter, then move to DONE.
REQ-015 DONE SHALL last one cycle, assert ready, and return to IDLE.
REQ-016 A read SHALL load RDM with mem[latched address] on the DONE cycle edge, visible while ready is high.
REQ-017 A write SHALL store the latched data into mem[latched address] and load RDM with that data on the same edge.
REQ-018 ready SHALL be high exactly WAIT_CYCLES+1 cycles after the accept edge.
REQ-019 Simultaneous req_rd and req_wr SHALL perform the write only; the read is dropped.
REQ-020 Requests while busy SHALL be ignored, not queued.
REQ-021 EndMem and dataIn changes after accept SHALL NOT affect the access in flight.
REQ-022 A read of an address written by the previous access SHALL return the new data.
REQ-023 RDM SHALL hold its value between accesses.

Reset
REQ-024 Reset SHALL force state IDLE, counter 0, ready 0, busy 0, RDM 8'h00, and perr 0 when present.
REQ-025 Reset mid-access SHALL abort it; an aborted write SHALL NOT modify storage.
REQ-026 Reset SHALL NOT clear the storage array.

Configuration
REQ-027 Macro NEANDER_MEM_PARITY_EN SHALL, when defined, add output perr (1 bit) and a 9th even-parity bit per word.
REQ-028 With the macro defined, writes SHALL store parity, and reads SHALL set perr with ready when stored parity mismatches the data; perr SHALL clear on the next accept.
REQ-029 Without the macro, port perr, the parity storage and the check logic SHALL be absent, and behaviour SHALL be otherwise identical.

Structure
REQ-030 A shared package neander_pkg SHALL hold the FSM state typedef (IDLE/WAIT/DONE), ADDR_W=8, DATA_W=8 and MEM_DEPTH=256.
REQ-031 One sub-module, neander_ram256x8, SHALL hold the synchronous-write storage array, with parity width selected by the macro.

Verification
REQ-032 The bench SHALL cover: reset, then req_wr with EndMem=8'h10 and dataIn=8'hA5 -> ready 2 cycles later, RDM=8'hA5; then req_rd at 8'h10 -> ready after 2 cycles, RDM=8'hA5.
REQ-033 The bench SHALL cover: WAIT_CYCLES=0 and WAIT_CYCLES=7 -> ready at 1 and 8 cycles after accept respectively, busy high for the same span.
REQ-034 The bench SHALL cover: req_rd and req_wr together, EndMem=8'hFF, dataIn=8'h3C -> only mem[8'hFF]=8'h3C written, RDM=8'h3C.
REQ-035 The bench SHALL cover: second req_rd while busy, plus EndMem changed to 8'h00 mid-access -> one ready pulse only, data from the originally latched address.
REQ-036 The bench SHALL cover: req_wr at 8'h20 with 8'h77, then reset in WAIT -> mem[8'h20] keeps its prior value, RDM=8'h00, ready stays 0.
REQ-037 The bench SHALL cover, with NEANDER_MEM_PARITY_EN defined: force a flipped stored parity bit at 8'h30 and read it -> perr=1 with ready; the next clean read gives perr=0.
